// File: rtl/serial_sub_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encoding and
// the counter-width helper.
package serial_sub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Ceiling log2, never less than 1 so a counter always has at least one bit.
  function automatic int clog2_w(input int value);
    int bits;
    bits = 0;
    while ((1 << bits) < value) bits++;
    if (bits < 1) bits = 1;
    return bits;
  endfunction

endpackage

// File: rtl/full_subtractor_dflow.sv
// Single-bit full subtractor cell in pure dataflow form:
// diff = a ^ b ^ br, borrow = (~a & b) | (~a & br) | (b & br).
module full_subtractor_dflow (
  input  logic a_in,
  input  logic b_in,
  input  logic br_in,
  output logic diff_out,
  output logic borrow_out
);

  assign diff_out   = a_in ^ b_in ^ br_in;
  assign borrow_out = (~a_in & b_in) | (~a_in & br_in) | (b_in & br_in);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes (a - b - bin) mod 2^WIDTH one bit per clock
// through a single full-subtractor cell, LSB first.
//
// Handshake: start_in is sampled on a rising edge and accepted only in IDLE or
// DONE (never in SHIFT). An accepted start latches a_in/b_in/bin_in; busy_out
// is high for the WIDTH cycles that follow, then done_out pulses for exactly
// one cycle together with the updated diff_out/borrow_out. busy_out and
// done_out are never high together. Reset wins over start.
//
// Optional feature: define SERIAL_SUB_OVF_EN to add overflow_out, the signed
// two's-complement overflow (borrow into MSB XOR borrow out of MSB).
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             start_in,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             bin_in,
  output logic             busy_out,
  output logic             done_out,
  output logic [WIDTH-1:0] diff_out,
  output logic             borrow_out,
  output logic [1:0]       dbg_state_out
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             overflow_out
`endif
);

  localparam int CW = clog2_w(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] part_q;
  logic             br_q;
  logic [CW-1:0]    cnt_q;
  logic             cell_d;
  logic             cell_bo;
  logic             accept;
  logic             last_bit;

  assign accept   = start_in && (state_q != ST_SHIFT);
  assign last_bit = (state_q == ST_SHIFT) && (cnt_q == LAST_BIT);

  full_subtractor_dflow u_cell (
    .a_in      (a_sh[0]),
    .b_in      (b_sh[0]),
    .br_in     (br_q),
    .diff_out  (cell_d),
    .borrow_out(cell_bo)
  );

  // State register.
  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic and status outputs decoded from the current state.
  always_comb begin
    state_d       = state_q;
    busy_out      = 1'b0;
    done_out      = 1'b0;
    dbg_state_out = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start_in) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy_out = 1'b1;
        if (cnt_q == LAST_BIT) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_out = 1'b1;
        state_d  = start_in ? ST_SHIFT : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand shift registers, borrow flop, bit counter and result registers.
  // Results are only written on the final SHIFT bit so they hold steady
  // while a new operation is in flight.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      a_sh       <= '0;
      b_sh       <= '0;
      part_q     <= '0;
      br_q       <= 1'b0;
      cnt_q      <= '0;
      diff_out   <= '0;
      borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      overflow_out <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= a_in;
      b_sh  <= b_in;
      br_q  <= bin_in;
      cnt_q <= '0;
    end else if (state_q == ST_SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      br_q   <= cell_bo;
      part_q <= {cell_d, part_q[WIDTH-1:1]};
      // Hold at the last index instead of wrapping.
      if (!last_bit) cnt_q <= cnt_q + CW'(1);
      if (last_bit) begin
        diff_out   <= {cell_d, part_q[WIDTH-1:1]};
        borrow_out <= cell_bo;
`ifdef SERIAL_SUB_OVF_EN
        // br_q is the borrow into the MSB, cell_bo the borrow out of it.
        overflow_out <= br_q ^ cell_bo;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=4). Covers the
// SERIAL_SUB_OVF_EN build when that macro is defined.
module tb_serial_subtractor;
  import serial_sub_pkg::*;

  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic bin;
  logic busy;
  logic done;
  logic [W-1:0] diff;
  logic borrow;
  logic [1:0] dbg_state;
  logic ovf;

  always #5 clk = ~clk;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk_in       (clk),
    .rst_in       (rst),
    .start_in     (start),
    .a_in         (a),
    .b_in         (b),
    .bin_in       (bin),
    .busy_out     (busy),
    .done_out     (done),
    .diff_out     (diff),
    .borrow_out   (borrow),
    .dbg_state_out(dbg_state)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .overflow_out (ovf)
`endif
  );

`ifndef SERIAL_SUB_OVF_EN
  assign ovf = 1'b0;
`endif

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] diff;
    logic         borrow;
    logic         ovf;
  } vec_t;

  vec_t vecs[8];
  logic [W-1:0] last_diff;

  // ---------------- driver tasks ----------------
  // Call at a negedge; start is high for one cycle (cycle k). Returns at the
  // negedge inside cycle k+1.
  task automatic start_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic bv_in);
    start = 1'b1;
    a     = av;
    b     = bv;
    bin   = bv_in;
    @(negedge clk);
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
  endtask

  // From cycle k+1: expect busy for W cycles with the old result held, then
  // done with the new result in cycle k+W+1. Returns in the done cycle.
  task automatic expect_op(input string tag, input logic [W-1:0] ed, input logic eb, input logic eo);
    for (int j = 0; j < W; j++) begin
      check({tag, " busy"}, 32'(busy), 32'd1);
      check({tag, " no_done_in_shift"}, 32'(done), 32'd0);
      check({tag, " diff_held"}, 32'(diff), 32'(last_diff));
      @(negedge clk);
    end
    exp_q.push_back(ed);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " busy_in_done"}, 32'(busy), 32'd0);
    check({tag, " diff"}, 32'(diff), 32'(exp_q.pop_front()));
    check({tag, " borrow"}, 32'(borrow), 32'(eb));
`ifdef SERIAL_SUB_OVF_EN
    check({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) check({tag, " ovf"}, 32'(ovf), 32'd0);
`endif
    last_diff = ed;
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    bin   = 1'b0;
    last_diff = '0;

    //            a      b      bin   diff   borrow ovf
    vecs[0] = '{4'h9, 4'h3, 1'b0, 4'h6, 1'b0, 1'b1}; // -7 - 3 wraps to +6
    vecs[1] = '{4'h3, 4'h9, 1'b0, 4'hA, 1'b1, 1'b1}; // 3 - (-7) = 10 overflows
    vecs[2] = '{4'h0, 4'h0, 1'b1, 4'hF, 1'b1, 1'b0};
    vecs[3] = '{4'hF, 4'hF, 1'b0, 4'h0, 1'b0, 1'b0};
    vecs[4] = '{4'h8, 4'h1, 1'b0, 4'h7, 1'b0, 1'b1};
    vecs[5] = '{4'h5, 4'h3, 1'b0, 4'h2, 1'b0, 1'b0};
    vecs[6] = '{4'h7, 4'hF, 1'b1, 4'h7, 1'b1, 1'b0};
    vecs[7] = '{4'h0, 4'h8, 1'b0, 4'h8, 1'b1, 1'b1};

    // Reset state.
    repeat (3) @(negedge clk);
    check("rst busy", 32'(busy), 32'd0);
    check("rst done", 32'(done), 32'd0);
    check("rst diff", 32'(diff), 32'd0);
    check("rst borrow", 32'(borrow), 32'd0);
    check("rst ovf", 32'(ovf), 32'd0);
    check("rst state", 32'(dbg_state), 32'(ST_IDLE));
    rst = 1'b0;
    @(negedge clk);
    check("idle busy", 32'(busy), 32'd0);

    // Table-driven operations, one idle cycle between each.
    for (int i = 0; i < 8; i++) begin
      start_op(vecs[i].a, vecs[i].b, vecs[i].bin);
      expect_op($sformatf("vec%0d", i), vecs[i].diff, vecs[i].borrow, vecs[i].ovf);
      @(negedge clk);
      check($sformatf("vec%0d done_one_cycle", i), 32'(done), 32'd0);
      check($sformatf("vec%0d idle_state", i), 32'(dbg_state), 32'(ST_IDLE));
    end

    // Start in SHIFT (cycle k+2) is ignored; operands are not resampled.
    start_op(4'h9, 4'h3, 1'b0);
    start = 1'b1; a = 4'h1; b = 4'h1; bin = 1'b1;
    @(negedge clk);
    start = 1'b0; a = '0; b = '0; bin = 1'b0;
    check("ign busy_k2", 32'(busy), 32'd1);
    repeat (2) @(negedge clk);
    check("ign busy_k4", 32'(busy), 32'd1);
    @(negedge clk);
    check("ign done", 32'(done), 32'd1);
    check("ign diff", 32'(diff), 32'h6);
    check("ign borrow", 32'(borrow), 32'd0);
    last_diff = 4'h6;
    @(negedge clk);

    // Back-to-back: start during DONE launches the next op immediately.
    start_op(4'h5, 4'h3, 1'b0);
    expect_op("b2b_first", 4'h2, 1'b0, 1'b0);
    start_op(4'h8, 4'h1, 1'b0);
    expect_op("b2b_second", 4'h7, 1'b0, 1'b1);
    @(negedge clk);
    check("b2b idle", 32'(done), 32'd0);

    // Reset mid-operation (cycle k+2) aborts with no done pulse.
    start_op(4'h3, 4'h9, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort busy", 32'(busy), 32'd0);
    check("abort diff", 32'(diff), 32'd0);
    check("abort borrow", 32'(borrow), 32'd0);
    check("abort done", 32'(done), 32'd0);
    begin
      logic saw_done;
      saw_done = 1'b0;
      for (int j = 0; j < 10; j++) begin
        if (done) saw_done = 1'b1;
        @(negedge clk);
      end
      check("abort no_done_pulse", 32'(saw_done), 32'd0);
    end
    last_diff = '0;

    // Reset and start together: reset wins.
    rst = 1'b1;
    start_op(4'h9, 4'h3, 1'b0);
    rst = 1'b0;
    check("rst_vs_start busy", 32'(busy), 32'd0);
    check("rst_vs_start state", 32'(dbg_state), 32'(ST_IDLE));

    // One more op after all that still works.
    start_op(4'hF, 4'hF, 1'b0);
    expect_op("final", 4'h0, 1'b0, 1'b0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: timeout reached");
    $fatal(1, "timeout");
  end

endmodule
